// File: rtl/hqm_list_sel_mem_rmw_ctl.sv
`default_nettype none
// ============================================================================
// Module   : hqm_list_sel_mem_rmw_ctl
// Purpose  : Serialises RD/WR/masked-RMW requests onto the list-select
//            single-port SRAM and returns read data via a credit-protected
//            response FIFO. Optional counters: HQM_LIST_SEL_MEM_RMW_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module hqm_list_sel_mem_rmw_ctl #(
   parameter int AW        = 11,
   parameter int DW        = 139,
   parameter int RSP_DEPTH = 2
) (
   input  logic          clk,
   input  logic          clk_rst,
`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
   input  logic          stat_clr,
   output logic [15:0]   stat_rd_cnt,
   output logic [15:0]   stat_wr_cnt,
   output logic [15:0]   stat_rmw_cnt,
`endif
   input  logic          req_v,
   output logic          req_ready,
   input  logic [1:0]    req_cmd,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [DW-1:0] req_mask,
   output logic          rsp_v,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_pwr_enable_b,
   output logic          err_pwr_drop
);

   localparam int CW = $clog2(RSP_DEPTH + 1);
   localparam int IW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);
   localparam logic [1:0] CMD_RD  = 2'b00;
   localparam logic [1:0] CMD_WR  = 2'b01;
   localparam logic [1:0] CMD_RMW = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RMW_RD   = 2'd1,
      ST_RMW_WAIT = 2'd2,
      ST_RMW_WR   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            mem_re_q, mem_re_d;
   logic            mem_we_q, mem_we_d;
   logic [AW-1:0]   mem_addr_q, mem_addr_d;
   logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
   logic [DW-1:0]   rmw_mask_q, rmw_mask_d;
   logic [DW-1:0]   rmw_wdata_q, rmw_wdata_d;
   logic            rd_iss_q, rd_iss_d;
   logic            rd_ret_q, rd_ret_d;
   logic [CW-1:0]   inflight_q, inflight_d;
   logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
   logic [DW-1:0]   fifo_q [RSP_DEPTH];
   logic [DW-1:0]   fifo_d [RSP_DEPTH];
   logic            err_q, err_d;

   logic            w_credit_ok;
   logic            w_acc;
   logic            w_rd_acc;
   logic            w_push;
   logic            w_pop;
   logic [IW-1:0]   w_widx;
   logic [CW:0]     w_credit_used;

   // Outstanding reads plus queued responses must fit the FIFO; writes never respond.
   assign w_credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
   assign w_credit_ok   = (w_credit_used < DEPTH_C) | (req_cmd == CMD_WR);
   assign req_ready     = (state_q == ST_IDLE) & ~mem_pwr_enable_b & w_credit_ok & ~clk_rst;
   assign w_acc         = req_v & req_ready;
   assign w_rd_acc      = w_acc & (req_cmd == CMD_RD);
   assign w_push        = rd_ret_q;
   assign w_pop         = rsp_v & rsp_ready;
   assign w_widx        = fifo_cnt_q[IW-1:0] - IW'(w_pop);

   always_comb begin
      state_d     = state_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rmw_mask_d  = rmw_mask_q;
      rmw_wdata_d = rmw_wdata_q;
      rd_iss_d    = 1'b0;
      rd_ret_d    = rd_iss_q;
      err_d       = err_q | (mem_pwr_enable_b & ((state_q != ST_IDLE) | (inflight_q != '0)));

      unique case (state_q)
         ST_IDLE: begin
            if (w_acc) begin
               case (req_cmd)
                  CMD_RD: begin
                     mem_re_d   = 1'b1;
                     mem_addr_d = req_addr;
                     rd_iss_d   = 1'b1;
                  end
                  CMD_WR: begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = req_addr;
                     mem_wdata_d = req_wdata;
                  end
                  CMD_RMW: begin
                     mem_re_d    = 1'b1;
                     mem_addr_d  = req_addr;
                     rmw_mask_d  = req_mask;
                     rmw_wdata_d = req_wdata;
                     state_d     = ST_RMW_RD;
                  end
                  default: ;
               endcase
            end
         end
         ST_RMW_RD: state_d = ST_RMW_WAIT;
         ST_RMW_WAIT: begin
            mem_wdata_d = (mem_rdata & ~rmw_mask_q) | (rmw_wdata_q & rmw_mask_q);
            mem_we_d    = 1'b1;
            state_d     = ST_RMW_WR;
         end
         ST_RMW_WR: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      case ({w_rd_acc, w_push})
         2'b10:   inflight_d = inflight_q + CW'(1);
         2'b01:   inflight_d = inflight_q - CW'(1);
         default: inflight_d = inflight_q;
      endcase

      // Head-at-slot-0 shifting FIFO so rsp_data comes straight off a flop.
      fifo_d     = fifo_q;
      fifo_cnt_d = fifo_cnt_q;
      if (w_pop) begin
         for (int i = 0; i < RSP_DEPTH - 1; i++) begin
            fifo_d[i] = fifo_q[i+1];
         end
         fifo_cnt_d = fifo_cnt_d - CW'(1);
      end
      if (w_push) begin
         fifo_d[w_widx] = mem_rdata;
         fifo_cnt_d     = fifo_cnt_d + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clk_rst) begin
         state_q     <= ST_IDLE;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rmw_mask_q  <= '0;
         rmw_wdata_q <= '0;
         rd_iss_q    <= 1'b0;
         rd_ret_q    <= 1'b0;
         inflight_q  <= '0;
         fifo_cnt_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            fifo_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rmw_mask_q  <= rmw_mask_d;
         rmw_wdata_q <= rmw_wdata_d;
         rd_iss_q    <= rd_iss_d;
         rd_ret_q    <= rd_ret_d;
         inflight_q  <= inflight_d;
         fifo_cnt_q  <= fifo_cnt_d;
         err_q       <= err_d;
         fifo_q      <= fifo_d;
      end
   end

   assign mem_re       = mem_re_q;
   assign mem_we       = mem_we_q;
   assign mem_addr     = mem_addr_q;
   assign mem_wdata    = mem_wdata_q;
   assign rsp_v        = (fifo_cnt_q != '0);
   assign rsp_data     = fifo_q[0];
   assign err_pwr_drop = err_q;

`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
   logic [15:0] rd_cnt_q, rd_cnt_d;
   logic [15:0] wr_cnt_q, wr_cnt_d;
   logic [15:0] rmw_cnt_q, rmw_cnt_d;

   function automatic logic [15:0] f_sat_inc(input logic [15:0] v, input logic inc,
                                             input logic clr);
      if (clr)                   return 16'h0000;
      if (inc && v != 16'hFFFF)  return v + 16'd1;
      return v;
   endfunction

   always_comb begin
      rd_cnt_d  = f_sat_inc(rd_cnt_q,  w_acc & (req_cmd == CMD_RD),  stat_clr);
      wr_cnt_d  = f_sat_inc(wr_cnt_q,  w_acc & (req_cmd == CMD_WR),  stat_clr);
      rmw_cnt_d = f_sat_inc(rmw_cnt_q, w_acc & (req_cmd == CMD_RMW), stat_clr);
   end

   always_ff @(posedge clk) begin
      if (clk_rst) begin
         rd_cnt_q  <= '0;
         wr_cnt_q  <= '0;
         rmw_cnt_q <= '0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_cnt_q  <= wr_cnt_d;
         rmw_cnt_q <= rmw_cnt_d;
      end
   end

   assign stat_rd_cnt  = rd_cnt_q;
   assign stat_wr_cnt  = wr_cnt_q;
   assign stat_rmw_cnt = rmw_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hqm_list_sel_mem_rmw_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hqm_list_sel_mem_rmw_ctl
// Purpose  : Directed self-checking bench for hqm_list_sel_mem_rmw_ctl with a
//            behavioural single-port SRAM (1-cycle read latency).
// Revision : 1.0  initial release
// ============================================================================
module tb_hqm_list_sel_mem_rmw_ctl;
   localparam int AW = 11;
   localparam int DW = 139;
   localparam logic [1:0] RD  = 2'b00;
   localparam logic [1:0] WR  = 2'b01;
   localparam logic [1:0] RMW = 2'b10;
   localparam logic [1:0] RSV = 2'b11;
   localparam logic [DW-1:0] ONES    = '1;
   localparam logic [DW-1:0] LOWFF   = {{(DW-8){1'b0}}, 8'hFF};
   localparam logic [DW-1:0] RMW_EXP = {{(DW-8){1'b1}}, 8'h00};
   localparam logic [DW-1:0] D_1234  = {{(DW-16){1'b0}}, 16'h1234};
   localparam logic [DW-1:0] D_ABCDE = {{(DW-20){1'b0}}, 20'hABCDE};

   logic          clk;
   logic          clk_rst;
   logic          req_v, req_ready;
   logic [1:0]    req_cmd;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata, req_mask;
   logic          rsp_v, rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          mem_re, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_pwr_enable_b;
   logic          err_pwr_drop;
`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
   logic          stat_clr;
   logic [15:0]   stat_rd_cnt, stat_wr_cnt, stat_rmw_cnt;
`endif

   int checks = 0;
   int errors = 0;

   hqm_list_sel_mem_rmw_ctl #(.AW(AW), .DW(DW), .RSP_DEPTH(2)) dut (
      .clk              (clk),
      .clk_rst          (clk_rst),
`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
      .stat_clr         (stat_clr),
      .stat_rd_cnt      (stat_rd_cnt),
      .stat_wr_cnt      (stat_wr_cnt),
      .stat_rmw_cnt     (stat_rmw_cnt),
`endif
      .req_v            (req_v),
      .req_ready        (req_ready),
      .req_cmd          (req_cmd),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .req_mask         (req_mask),
      .rsp_v            (rsp_v),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .mem_re           (mem_re),
      .mem_we           (mem_we),
      .mem_addr         (mem_addr),
      .mem_wdata        (mem_wdata),
      .mem_rdata        (mem_rdata),
      .mem_pwr_enable_b (mem_pwr_enable_b),
      .err_pwr_drop     (err_pwr_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [DW-1:0] sram [2048];
   always @(posedge clk) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= sram[mem_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
`endif

   // Present a request and hold it until accepted (bounded), then drop req_v.
   task automatic do_req(input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] mk);
      int n = 0;
      req_v = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd; req_mask = mk;
      #1;
      while (!req_ready && n < 20) begin
         tick();
         n++;
      end
      chk1("accept_timeout", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
   endtask

   initial begin
      clk_rst = 1'b1; req_v = 1'b0; req_cmd = RD; req_addr = '0;
      req_wdata = '0; req_mask = '0; rsp_ready = 1'b1; mem_pwr_enable_b = 1'b0;
`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
      stat_clr = 1'b0;
`endif
      tick(); tick();
      chk1("rst_mem_re", mem_re, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk1("rst_rsp_v", rsp_v, 1'b0);
      chk1("rst_err", err_pwr_drop, 1'b0);
      chka("rst_mem_addr", mem_addr, '0);
      chkw("rst_mem_wdata", mem_wdata, '0);
      chkw("rst_rsp_data", rsp_data, '0);
      chk1("rst_ready_in_reset", req_ready, 1'b0);
      clk_rst = 1'b0; #1;
      chk1("rst_ready_after", req_ready, 1'b1);

      // WR 0x005 then RD 0x005 back-to-back
      req_v = 1'b1; req_cmd = WR; req_addr = 11'h005; req_wdata = D_1234; #1;
      chk1("wr_ready", req_ready, 1'b1);
      tick();
      chk1("wr_we_t1", mem_we, 1'b1);
      chk1("wr_re_t1", mem_re, 1'b0);
      chka("wr_addr_t1", mem_addr, 11'h005);
      chkw("wr_wdata_t1", mem_wdata, D_1234);
      req_cmd = RD; #1;
      chk1("rd_ready", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
      chk1("rd_re_t1", mem_re, 1'b1);
      chk1("rd_we_t1", mem_we, 1'b0);
      chka("rd_addr_t1", mem_addr, 11'h005);
      tick();
      chk1("rd_rspv_t2", rsp_v, 1'b0);
      tick();
      chk1("rd_rspv_t3", rsp_v, 1'b1);
      chkw("rd_data_t3", rsp_data, D_1234);
      tick();
      chk1("rd_popped", rsp_v, 1'b0);

      do_req(WR, 11'h7FF, ONES, '0);
      do_req(WR, 11'h010, D_ABCDE, '0);

      // RMW 0x7FF: all-ones merged with wdata=0 under mask 0xFF
      req_v = 1'b1; req_cmd = RMW; req_addr = 11'h7FF; req_wdata = '0; req_mask = LOWFF; #1;
      chk1("rmw_ready", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
      chk1("rmw_re_t1", mem_re, 1'b1);
      chk1("rmw_we_t1", mem_we, 1'b0);
      chka("rmw_addr_t1", mem_addr, 11'h7FF);
      chk1("rmw_ready_t1", req_ready, 1'b0);
      tick();
      chk1("rmw_re_t2", mem_re, 1'b0);
      chk1("rmw_we_t2", mem_we, 1'b0);
      chk1("rmw_ready_t2", req_ready, 1'b0);
      tick();
      chk1("rmw_we_t3", mem_we, 1'b1);
      chk1("rmw_re_t3", mem_re, 1'b0);
      chka("rmw_addr_t3", mem_addr, 11'h7FF);
      chkw("rmw_wdata_t3", mem_wdata, RMW_EXP);
      chk1("rmw_ready_t3", req_ready, 1'b0);
      tick();
      chk1("rmw_ready_t4", req_ready, 1'b1);
      chk1("rmw_we_t4", mem_we, 1'b0);
      chk1("rmw_no_rsp", rsp_v, 1'b0);

      // Credit limit: three RDs with the consumer stalled
      rsp_ready = 1'b0;
      req_v = 1'b1; req_cmd = RD; req_addr = 11'h005; #1;
      chk1("cr_rd1_ready", req_ready, 1'b1);
      tick();
      req_addr = 11'h7FF; #1;
      chk1("cr_rd2_ready", req_ready, 1'b1);
      tick();
      req_addr = 11'h010; #1;
      chk1("cr_rd3_blocked", req_ready, 1'b0);
      tick();
      chk1("cr_rspv", rsp_v, 1'b1);
      chkw("cr_head1", rsp_data, D_1234);
      chk1("cr_blocked_d", req_ready, 1'b0);
      tick();
      chk1("cr_blocked_e", req_ready, 1'b0);
      chkw("cr_head1_held", rsp_data, D_1234);
      tick();
      chk1("cr_blocked_f", req_ready, 1'b0);
      chk1("cr_no_issue", mem_re, 1'b0);
      rsp_ready = 1'b1;
      tick();
      chkw("cr_head2", rsp_data, RMW_EXP);
      chk1("cr_rd3_ready", req_ready, 1'b1);
      rsp_ready = 1'b0;
      tick();
      req_v = 1'b0;
      chk1("cr_rd3_re", mem_re, 1'b1);
      chka("cr_rd3_addr", mem_addr, 11'h010);
      tick(); tick();
      chk1("cr_full_again", req_ready, 1'b0);
      chkw("cr_head2_held", rsp_data, RMW_EXP);
      rsp_ready = 1'b1;
      tick();
      chk1("cr_rspv3", rsp_v, 1'b1);
      chkw("cr_head3", rsp_data, D_ABCDE);
      tick();
      chk1("cr_drained", rsp_v, 1'b0);

      // Reserved command: accepted, no SRAM access
      req_v = 1'b1; req_cmd = RSV; req_addr = 11'h005; #1;
      chk1("rsv_ready", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
      chk1("rsv_no_re", mem_re, 1'b0);
      chk1("rsv_no_we", mem_we, 1'b0);
      chk1("rsv_still_ready", req_ready, 1'b1);

      // Powered down in IDLE
      mem_pwr_enable_b = 1'b1; req_v = 1'b1; req_cmd = RD; #1;
      chk1("pwr_ready", req_ready, 1'b0);
      tick();
      chk1("pwr_no_re", mem_re, 1'b0);
      chk1("pwr_no_we", mem_we, 1'b0);
      chk1("pwr_idle_no_err", err_pwr_drop, 1'b0);
      req_v = 1'b0; mem_pwr_enable_b = 1'b0;

      // Power drop during RMW_WAIT
      req_v = 1'b1; req_cmd = RMW; req_addr = 11'h7FF; req_wdata = ONES; req_mask = LOWFF; #1;
      chk1("pe_ready", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
      tick();
      mem_pwr_enable_b = 1'b1;
      tick();
      chk1("pe_err", err_pwr_drop, 1'b1);
      chk1("pe_we_completes", mem_we, 1'b1);
      chkw("pe_wdata", mem_wdata, ONES);
      mem_pwr_enable_b = 1'b0;
      tick();
      chk1("pe_err_sticky1", err_pwr_drop, 1'b1);
      tick();
      chk1("pe_err_sticky2", err_pwr_drop, 1'b1);

      // Reset at T+2 of an RMW aborts it
      req_v = 1'b1; req_cmd = RMW; req_addr = 11'h010; req_wdata = '0; req_mask = ONES; #1;
      chk1("rr_ready", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
      tick();
      clk_rst = 1'b1;
      tick();
      chk1("rr_no_we", mem_we, 1'b0);
      chk1("rr_no_re", mem_re, 1'b0);
      chk1("rr_err_clr", err_pwr_drop, 1'b0);
      chk1("rr_rspv", rsp_v, 1'b0);
      chka("rr_addr", mem_addr, '0);
      chkw("rr_wdata", mem_wdata, '0);
      clk_rst = 1'b0;
      req_v = 1'b1; req_cmd = RD; req_addr = 11'h010; #1;
      chk1("rr_rd_ready", req_ready, 1'b1);
      tick();
      req_v = 1'b0;
      chk1("rr_rd_re", mem_re, 1'b1);
      chk1("rr_rd_we", mem_we, 1'b0);
      tick(); tick();
      chk1("rr_rd_rspv", rsp_v, 1'b1);
      chkw("rr_rd_data", rsp_data, D_ABCDE);
      tick();

`ifdef HQM_LIST_SEL_MEM_RMW_STATS_EN
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk16("st_clr0_rd", stat_rd_cnt, 16'd0);
      do_req(RD,  11'h005, '0, '0);
      do_req(WR,  11'h020, D_1234, '0);
      do_req(RD,  11'h005, '0, '0);
      do_req(WR,  11'h021, D_1234, '0);
      do_req(RD,  11'h005, '0, '0);
      do_req(RMW, 11'h020, '0, LOWFF);
      tick(); tick(); tick(); tick(); tick();
      chk16("st_rd", stat_rd_cnt, 16'd3);
      chk16("st_wr", stat_wr_cnt, 16'd2);
      chk16("st_rmw", stat_rmw_cnt, 16'd1);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk16("st_clr_rd", stat_rd_cnt, 16'd0);
      chk16("st_clr_wr", stat_wr_cnt, 16'd0);
      chk16("st_clr_rmw", stat_rmw_cnt, 16'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/hqm_list_sel_mem_rmw_ctl.md
Name: hqm_list_sel_mem_rmw_ctl

Overview:
- Request sequencer directly upstream of the list-select 2048x139 power-gated single-port SRAM.
- Accepts read, write and masked read-modify-write (RMW) requests over valid/ready.
- Serialises the requests onto the SRAM's single re/we/addr/wdata port and returns read data through a credit-protected response FIFO.
- Blocks new requests while the SRAM is power-gated.

Parameters:
- AW, 11, address width (2048 entries).
- DW, 139, data width.
- RSP_DEPTH, 2, response FIFO depth; sets the maximum number of outstanding reads.

Ports:
- clk  in  1  clock.
- clk_rst  in  1  reset, synchronous, active-high.
- req_v  in  1  request valid.
- req_ready  out  1  request accepted when req_v & req_ready.
- req_cmd  in  2  00=RD, 01=WR, 10=RMW, 11=reserved.
- req_addr  in  AW  entry address.
- req_wdata  in  DW  write/merge data.
- req_mask  in  DW  RMW bit mask (1 = take req_wdata bit).
- rsp_v  out  1  read response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DW  read data.
- mem_re  out  1  to SRAM re.
- mem_we  out  1  to SRAM we.
- mem_addr  out  AW  to SRAM addr.
- mem_wdata  out  DW  to SRAM wdata.
- mem_rdata  in  DW  from SRAM rdata; valid the cycle after mem_re.
- mem_pwr_enable_b  in  1  SRAM pwr_enable_b_out; 1 = powered down.
- err_pwr_drop  out  1  sticky: power dropped with an operation in flight.

Behaviour:
- Reset (clk_rst=1 at posedge): all outputs 0 next cycle; FIFO empty; FSM=IDLE; in-flight count 0; err_pwr_drop 0. Reset mid-operation aborts it; no SRAM access is issued afterwards.
- mem_re, mem_we, mem_addr and mem_wdata are registered outputs. mem_re and mem_we are never both 1.
- req_ready = (state==IDLE) & !mem_pwr_enable_b & (inflight + fifo_count < RSP_DEPTH). The credit term is ignored for WR.
- FSM states and transitions:
  - IDLE: accepts RD/WR/RMW and stays IDLE for RD/WR. A reserved cmd is accepted and dropped with no SRAM access.
  - RMW_RD: mem_re=1 with the captured address.
  - RMW_WAIT: mem_rdata arrives; merged = (mem_rdata & ~mask) | (wdata & mask), registered.
  - RMW_WR: mem_we=1, mem_wdata=merged; returns to IDLE.
- Latencies (accept at cycle T):
  - RD: mem_re at T+1, mem_rdata at T+2, written to FIFO; rsp_v at T+3 if FIFO was empty.
  - WR: mem_we at T+1; no response.
  - RMW: mem_re T+1, merge T+2, mem_we T+3. req_ready=0 for T+1..T+3; next accept at T+4 earliest. RMW produces no response.
- Back-to-back RD/WR are accepted every cycle. A RD issued after a WR to the same address returns the new data, because the port is sequential.
- Response FIFO: in-order, registered output, rsp_data held stable while rsp_v & !rsp_ready. Simultaneous push and pop at full is allowed. The credit rule guarantees the FIFO never overflows.
- inflight counts RDs issued whose data is not yet in the FIFO (0..RSP_DEPTH).
- Power: if mem_pwr_enable_b=1 while state!=IDLE or inflight!=0, err_pwr_drop sets and holds until reset. The FSM still completes its sequence with no recovery.

Optional Feature:
- Macro HQM_LIST_SEL_MEM_RMW_STATS_EN.
- Defined:
  - Adds outputs stat_rd_cnt, stat_wr_cnt and stat_rmw_cnt (16 bits each), plus input stat_clr.
  - Counters increment on each accepted RD, WR and RMW respectively and saturate at 0xFFFF.
  - stat_clr=1 zeroes all three next cycle, with priority over increment.
  - All three reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then WR addr 0x005 data 0x1234, then RD 0x005 -> mem_we T+1; mem_re next; rsp_v 3 cycles after RD accept with rsp_data=0x1234.
- RMW addr 0x7FF, mem holds all-ones, wdata=0, mask=0xFF -> mem_re T+1, mem_we T+3 with low 8 bits 0 and others 1; req_ready low T+1..T+3.
- rsp_ready=0, three RDs back-to-back -> first two accepted, req_ready=0 on third; after one pop, third accepted; FIFO never exceeds 2.
- mem_pwr_enable_b=1 in IDLE -> req_ready=0, no mem_re/mem_we; drive it to 1 at T+2 of an RMW -> err_pwr_drop=1 sticky.
- Assert clk_rst at T+2 of an RMW -> no mem_we at T+3; all outputs 0; the next RD after reset works.
- Stats build: 3 RD, 2 WR, 1 RMW -> counts 3/2/1; stat_clr -> 0/0/0.
